// File: rtl/seq_alu_if.sv
// Operation request/result bundle for seq_alu: the requester drives start/op/a/b
// and receives the registered result, flags, busy and the one-cycle done pulse.
interface seq_alu_if;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] alu_result;
    logic [2:0]  flags;
    logic        busy;
    logic        done;

    modport master (
        output start, op, a, b,
        input  alu_result, flags, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output alu_result, flags, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential 8-bit ALU: single-cycle logic/arithmetic ops plus an optional 8-cycle
// shift-and-add multiplier, enabled by defining SEQ_ALU_MUL_EN.
module seq_alu (
    input  logic      clock,
    input  logic      reset,
    seq_alu_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;

`ifdef SEQ_ALU_MUL_EN
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] acc_sum;
`endif

    // Single-cycle datapath evaluated on the live operands at the start edge.
    logic [8:0]  add_sum;
    logic [8:0]  sub_diff;
    logic [15:0] alu_res;
    logic        alu_carry;
    logic [2:0]  alu_flags;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        sub_diff  = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res   = 16'h0000;
        alu_carry = 1'b0;
        case (op_t'(bus.op))
            OP_ADD: begin alu_res = {7'b0, add_sum};          alu_carry = add_sum[8];  end
            OP_SUB: begin alu_res = {8'h00, sub_diff[7:0]};   alu_carry = sub_diff[8]; end
            OP_AND: alu_res = {8'h00, bus.a & bus.b};
            OP_OR:  alu_res = {8'h00, bus.a | bus.b};
            OP_XOR: alu_res = {8'h00, bus.a ^ bus.b};
            OP_SHL: begin alu_res = {8'h00, bus.a[6:0], 1'b0}; alu_carry = bus.a[7]; end
            OP_SHR: begin alu_res = {8'h00, 1'b0, bus.a[7:1]}; alu_carry = bus.a[0]; end
            default: ;
        endcase
        alu_flags = {alu_res[7], alu_carry, (alu_res == 16'h0000)};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    result_d = alu_res;
                    flags_d  = alu_flags;
                    state_d  = ST_DONE;
`ifdef SEQ_ALU_MUL_EN
                    // Multiply keeps the old result visible until the product is final.
                    if (op_t'(bus.op) == OP_MUL) begin
                        result_d = result_q;
                        flags_d  = flags_q;
                        mcand_d  = {8'h00, bus.a};
                        mplier_d = bus.b;
                        acc_d    = 16'h0000;
                        cnt_d    = 3'd0;
                        state_d  = ST_MUL;
                    end
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = acc_sum;
                    flags_d  = {acc_sum[15], (acc_sum[15:8] != 8'h00), (acc_sum == 16'h0000)};
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= 16'h0000;
            flags_q  <= 3'b000;
`ifdef SEQ_ALU_MUL_EN
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            acc_q    <= 16'h0000;
            cnt_q    <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.alu_result = result_q;
    assign bus.flags      = flags_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vectors plus random ops against an
// arithmetic reference model; follows SEQ_ALU_MUL_EN to pick the expected MUL behaviour.
module tb_seq_alu;

`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] prev_res;
    logic [2:0]  prev_flags;

    seq_alu_if bus ();

    seq_alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the operation definitions, using integer arithmetic.
    function automatic void model(input int o, input int x, input int y,
                                  output logic [15:0] res, output logic [2:0] flg);
        int r;
        bit c;
        bit n;
        r = 0;
        c = 1'b0;
        case (o)
            0: begin r = x + y;             c = (r > 255); end
            1: begin r = (x - y + 256) % 256; c = (x < y); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin r = (x * 2) % 256;     c = (x > 127); end
            6: begin r = x / 2;             c = (x % 2 == 1); end
            default: begin
                if (MUL_EN) begin r = x * y; c = (r > 255); end
                else        begin r = 0;     c = 1'b0;      end
            end
        endcase
        n   = (MUL_EN && o == 7) ? (((r >> 15) & 1) == 1) : (((r >> 7) & 1) == 1);
        res = 16'(r);
        flg = {n, c, (r == 0)};
    endfunction

    task automatic run_op(input int o, input int x, input int y);
        logic [15:0] exp_res;
        logic [2:0]  exp_flg;
        int          exp_lat;
        int          cyc;
        model(o, x, y, exp_res, exp_flg);
        exp_lat = (MUL_EN && o == 7) ? 9 : 1;

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 3'(o);
        bus.a     = 8'(x);
        bus.b     = 8'(y);
        @(negedge clock);
        // Scramble operands after the start edge; the captured op must not notice.
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            check("busy_during_op", 16'(bus.busy), 16'd1);
            check("result_held_during_op", bus.alu_result, prev_res);
            check("flags_held_during_op", 16'(bus.flags), 16'(prev_flags));
            bus.start = (cyc == 3);
            @(negedge clock);
            cyc++;
        end
        bus.start = 1'b0;
        check("done_pulse", 16'(bus.done), 16'd1);
        check("latency", 16'(cyc), 16'(exp_lat));
        check("busy_in_done", 16'(bus.busy), 16'd1);
        check("result", bus.alu_result, exp_res);
        check("flags", 16'(bus.flags), 16'(exp_flg));

        // A start presented during the done cycle must be dropped, not queued.
        bus.start = 1'b1;
        bus.op    = 3'($urandom);
        @(negedge clock);
        bus.start = 1'b0;
        check("done_single_cycle", 16'(bus.done), 16'd0);
        check("idle_after_done", 16'(bus.busy), 16'd0);
        @(negedge clock);
        check("start_in_done_ignored", 16'(bus.busy), 16'd0);
        check("result_holds_idle", bus.alu_result, exp_res);
        prev_res   = exp_res;
        prev_flags = exp_flg;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        prev_res   = 16'h0000;
        prev_flags = 3'b000;
        repeat (2) @(negedge clock);
        check("reset_result", bus.alu_result, 16'h0000);
        check("reset_flags", 16'(bus.flags), 16'h0000);
        check("reset_busy", 16'(bus.busy), 16'd0);
        check("reset_done", 16'(bus.done), 16'd0);
        reset = 1'b0;

        run_op(0, 8'hF0, 8'h20);
        check("add_f0_20_result", bus.alu_result, 16'h0110);
        check("add_f0_20_flags", 16'(bus.flags), 16'h0002);
        run_op(1, 8'h05, 8'h05);
        check("sub_eq_result", bus.alu_result, 16'h0000);
        check("sub_eq_flags", 16'(bus.flags), 16'h0001);
        run_op(1, 8'h03, 8'h05);
        check("sub_borrow_result", bus.alu_result, 16'h00FE);
        check("sub_borrow_flags", 16'(bus.flags), 16'h0006);
        run_op(6, 8'h01, 8'h5A);
        check("shr_result", bus.alu_result, 16'h0000);
        check("shr_flags", 16'(bus.flags), 16'h0003);
        run_op(5, 8'h81, 8'hA5);
        check("shl_result", bus.alu_result, 16'h0002);
        check("shl_flags", 16'(bus.flags), 16'h0002);
`ifdef SEQ_ALU_MUL_EN
        run_op(7, 8'hFF, 8'hFF);
        check("mul_ff_result", bus.alu_result, 16'hFE01);
        check("mul_ff_flags", 16'(bus.flags), 16'h0006);
`else
        run_op(7, 8'h10, 8'h10);
        check("mul_off_result", bus.alu_result, 16'h0000);
        check("mul_off_flags", 16'(bus.flags), 16'h0001);
`endif

        // Reset four cycles into a multiply, with a competing start on the reset edge.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 3'd7;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        @(negedge clock);
        bus.start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check("abort_done_before_reset", 16'(bus.done), 16'((!MUL_EN && c == 1) ? 1 : 0));
            if (c < 3) @(negedge clock);
        end
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd0;
        @(negedge clock);
        check("abort_done", 16'(bus.done), 16'd0);
        check("abort_busy", 16'(bus.busy), 16'd0);
        check("abort_result", bus.alu_result, 16'h0000);
        check("abort_flags", 16'(bus.flags), 16'h0000);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        check("start_with_reset_ignored", 16'(bus.busy), 16'd0);
        check("no_done_after_abort", 16'(bus.done), 16'd0);
        prev_res   = 16'h0000;
        prev_flags = 3'b000;
        run_op(0, 8'h01, 8'h01);
        check("add_after_abort", bus.alu_result, 16'h0002);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
